// File: rtl/divider.sv
// ============================================================================
// divider
// ----------------------------------------------------------------------------
// Multi-cycle 32-bit integer divider for the execute stage (DIV / DIVU).
// A restoring shift-subtract engine retires one quotient bit per cycle, so a
// normal divide takes 32 BUSY cycles plus one DONE cycle that presents the
// result. Divide-by-zero skips the engine and goes straight to DONE.
//
// Ports
//   clk         in   1   pipeline clock, rising edge
//   rst         in   1   synchronous active-high reset
//   start       in   1   DIV/DIVU issue request, only looked at in IDLE
//   signed_div  in   1   1 = DIV (signed), 0 = DIVU (unsigned)
//   opa         in  32   dividend
//   opb         in  32   divisor
//   cancel      in   1   pipeline flush / exception abort, beats start
//   stall       out  1   divide in progress, freezes F/D/E
//   ready       out  1   one-cycle pulse, result valid for HI/LO write
//   result      out 64   {HI = remainder, LO = quotient}
// ============================================================================
module divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        cancel,
    output logic        stall,
    output logic        ready,
    output logic [63:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic [5:0]  r_count;
    logic [31:0] r_quot;
    logic [32:0] r_rem;
    logic [31:0] r_divisor;
    logic        r_negQ;
    logic        r_negR;
    logic [63:0] r_result;

    logic        w_accept;
    logic        w_divZero;
    logic        w_lastStep;
    logic [31:0] w_magA;
    logic [31:0] w_magB;
    logic [32:0] w_shifted;
    logic [32:0] w_diff;
    logic [31:0] w_quotFinal;
    logic [31:0] w_remFinal;
    logic [63:0] w_final;

    // A new divide is taken only from IDLE, and a same-cycle cancel wins.
    assign w_accept   = (r_state == IDLE) && start && !cancel;
    assign w_divZero  = (opb == 32'd0);
    assign w_lastStep = (r_count == 6'd31);

    // Operand magnitudes; in unsigned mode the operands pass straight through.
    // The magnitude of 0x80000000 is 0x80000000 read as unsigned, which is
    // what makes the signed overflow case come out right without special casing.
    assign w_magA = (signed_div && opa[31]) ? (~opa + 32'd1) : opa;
    assign w_magB = (signed_div && opb[31]) ? (~opb + 32'd1) : opb;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and try subtracting the divisor. Bit 32 of the difference is
    // set exactly when the trial subtraction went negative.
    assign w_shifted = {r_rem[31:0], r_quot[31]};
    assign w_diff    = w_shifted - {1'b0, r_divisor};

    // Sign fix-up at the end: quotient negated when signs differ, remainder
    // takes the dividend's sign. Divide-by-zero loads values with both flags
    // clear so they appear unchanged.
    assign w_quotFinal = r_negQ ? (~r_quot + 32'd1) : r_quot;
    assign w_remFinal  = r_negR ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];
    assign w_final     = {w_remFinal, w_quotFinal};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake outputs. Reset gates stall/ready directly so
    // the pipeline sees neither while rst is high, whatever the state holds.
    always_comb begin
        w_nextState = r_state;
        stall       = 1'b0;
        ready       = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = w_divZero ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (w_lastStep) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase

        if (cancel) begin
            w_nextState = IDLE;
        end

        stall = !rst && (w_accept || (r_state == BUSY));
        ready = !rst && (r_state == DONE) && !cancel;
    end

    // Divide engine: latch operands on accept, then one step per BUSY cycle.
    // r_quot starts as the dividend magnitude and is shifted left as quotient
    // bits enter at the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= 6'd0;
            r_quot    <= 32'd0;
            r_rem     <= 33'd0;
            r_divisor <= 32'd0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_count <= 6'd0;
                        if (w_divZero) begin
                            r_quot    <= 32'hFFFF_FFFF;
                            r_rem     <= {1'b0, opa};
                            r_divisor <= opb;
                            r_negQ    <= 1'b0;
                            r_negR    <= 1'b0;
                        end else begin
                            r_quot    <= w_magA;
                            r_rem     <= 33'd0;
                            r_divisor <= w_magB;
                            r_negQ    <= signed_div && (opa[31] ^ opb[31]);
                            r_negR    <= signed_div && opa[31];
                        end
                    end
                end
                BUSY: begin
                    r_count <= r_count + 6'd1;
                    if (!w_diff[32]) begin
                        r_rem  <= w_diff;
                        r_quot <= {r_quot[30:0], 1'b1};
                    end else begin
                        r_rem  <= w_shifted;
                        r_quot <= {r_quot[30:0], 1'b0};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Held result: captured as DONE completes, so it persists until the next
    // successful DONE. A cancelled DONE leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= 64'd0;
        end else if ((r_state == DONE) && !cancel) begin
            r_result <= w_final;
        end
    end

    // During the ready cycle the fresh value is forwarded so HI/LO can be
    // written in that same cycle.
    assign result = ready ? w_final : (rst ? 64'd0 : r_result);

endmodule

// File: tb/tb_divider.sv
// ============================================================================
// tb_divider
// ----------------------------------------------------------------------------
// Self-checking bench for divider: directed corner cases (unsigned, signed,
// overflow, divide-by-zero, cancel, reset mid-divide, start held high) and a
// batch of random divides checked against a plain-arithmetic reference.
// ============================================================================
module tb_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        cancel;
    logic        stall;
    logic        ready;
    logic [63:0] result;

    int          total;
    int          bad;
    logic [63:0] lastResult;

    divider dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .opa        (opa),
        .opb        (opb),
        .cancel     (cancel),
        .stall      (stall),
        .ready      (ready),
        .result     (result)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference divide using 64-bit integer arithmetic: truncating division
    // gives the quotient rounded toward zero and a remainder with the
    // dividend's sign, and 64 bits leave room for -2^31 / -1.
    function automatic logic [63:0] refDiv(input bit sd, input logic [31:0] a, input logic [31:0] b);
        longint na;
        longint nb;
        longint q;
        longint r;
        if (b == 32'd0) begin
            return {a, 32'hFFFF_FFFF};
        end
        na = sd ? longint'(signed'(a)) : longint'(a);
        nb = sd ? longint'(signed'(b)) : longint'(b);
        q  = na / nb;
        r  = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    // One comparison: count it, and report a failure with tag, observed and expected.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one divide at the current cycle (cycle 0) and follow it to ready.
    // Checks stall at cycle 0, stall throughout the wait, latency, result,
    // stall low at ready, then ready dropping and result holding afterwards.
    // With holdStart set, start stays high with scrambled operands during the
    // operation, which must be ignored.
    task automatic applyStimulus(input bit sd, input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] expRes, input int expLat,
                                 input bit holdStart, input string tag);
        int lat;
        int stallBad;
        lat      = 100;
        stallBad = 0;
        start      = 1'b1;
        signed_div = sd;
        opa        = a;
        opb        = b;
        @(negedge clk);
        checkOutput({tag, ".stall0"}, 64'(stall), 64'd1);
        nextCycle();
        for (int c = 1; c < 100; c++) begin
            if (holdStart) begin
                start      = 1'b1;
                signed_div = ~sd;
                opa        = $urandom;
                opb        = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (ready === 1'b1) begin
                lat = c;
                break;
            end
            if (stall !== 1'b1) stallBad++;
            nextCycle();
        end
        start      = 1'b0;
        signed_div = 1'b0;
        opa        = 32'd0;
        opb        = 32'd0;
        checkOutput({tag, ".latency"}, 64'(lat), 64'(expLat));
        checkOutput({tag, ".stallGaps"}, 64'(stallBad), 64'd0);
        checkOutput({tag, ".stallAtReady"}, 64'(stall), 64'd0);
        checkOutput({tag, ".result"}, result, expRes);
        lastResult = expRes;
        nextCycle();
        @(negedge clk);
        checkOutput({tag, ".readyPulse"}, 64'(ready), 64'd0);
        checkOutput({tag, ".hold"}, result, lastResult);
        nextCycle();
    endtask

    initial begin
        int readySeen;
        bit sd;
        logic [31:0] a;
        logic [31:0] b;

        total      = 0;
        bad        = 0;
        lastResult = 64'd0;
        rst        = 1'b1;
        start      = 1'b1;
        signed_div = 1'b0;
        opa        = 32'd77;
        opb        = 32'd0;
        cancel     = 1'b0;

        // Reset held with start high: nothing may leak out.
        repeat (2) nextCycle();
        @(negedge clk);
        checkOutput("reset.stall", 64'(stall), 64'd0);
        checkOutput("reset.ready", 64'(ready), 64'd0);
        checkOutput("reset.result", result, 64'd0);
        nextCycle();
        rst   = 1'b0;
        start = 1'b0;
        opa   = 32'd0;
        nextCycle();
        @(negedge clk);
        checkOutput("postReset.result", result, 64'd0);
        nextCycle();

        // Directed divides.
        applyStimulus(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b0, "divu100_7");
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 1'b0, "divNeg7_2");
        applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33, 1'b0, "div7_neg2");
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33, 1'b0, "divOverflow");
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33, 1'b0, "divuMax_1");
        applyStimulus(1'b0, 32'h0000_1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF}, 1, 1'b0, "divuZero");
        applyStimulus(1'b1, 32'h8000_0001, 32'd0, {32'h8000_0001, 32'hFFFF_FFFF}, 1, 1'b0, "divZero");
        applyStimulus(1'b0, 32'd1000, 32'd33, {32'd10, 32'd30}, 33, 1'b1, "startHeld");

        // Cancel mid-operation at cycle 10.
        start      = 1'b1;
        signed_div = 1'b0;
        opa        = 32'd1000;
        opb        = 32'd3;
        nextCycle();
        start = 1'b0;
        repeat (9) nextCycle();
        cancel = 1'b1;
        @(negedge clk);
        checkOutput("cancel.stallAtCancel", 64'(stall), 64'd1);
        nextCycle();
        cancel = 1'b0;
        @(negedge clk);
        checkOutput("cancel.stallAfter", 64'(stall), 64'd0);
        checkOutput("cancel.result", result, lastResult);
        readySeen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready === 1'b1) readySeen++;
        end
        checkOutput("cancel.noReady", 64'(readySeen), 64'd0);
        checkOutput("cancel.resultHeld", result, lastResult);
        nextCycle();

        // Cancel together with start in IDLE: must stay idle.
        start  = 1'b1;
        cancel = 1'b1;
        opa    = 32'd5;
        opb    = 32'd1;
        @(negedge clk);
        checkOutput("cancelStart.stall", 64'(stall), 64'd0);
        nextCycle();
        start  = 1'b0;
        cancel = 1'b0;
        @(negedge clk);
        checkOutput("cancelStart.stayIdle", 64'(stall), 64'd0);
        checkOutput("cancelStart.ready", 64'(ready), 64'd0);
        nextCycle();

        // Reset at cycle 5 of a divide, new divide at cycle 7.
        start      = 1'b1;
        signed_div = 1'b0;
        opa        = 32'd50000;
        opb        = 32'd9;
        nextCycle();
        start = 1'b0;
        repeat (4) nextCycle();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstMid.stallDuring", 64'(stall), 64'd0);
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstMid.stall", 64'(stall), 64'd0);
        checkOutput("rstMid.ready", 64'(ready), 64'd0);
        checkOutput("rstMid.result", result, 64'd0);
        nextCycle();
        lastResult = 64'd0;
        applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd7, refDiv(1'b1, 32'hFFFF_FF9C, 32'd7), 33, 1'b0, "rstMid.restart");

        // Random divides against the reference model.
        for (int i = 0; i < 14; i++) begin
            sd = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 4))
                0:       b = $urandom_range(1, 15);
                1:       b = 32'd0;
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            applyStimulus(sd, a, b, refDiv(sd, a, b), (b == 32'd0) ? 1 : 33, 1'b0, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL have exactly one clock and one reset; the reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  Pipeline clock; all state updates on the rising edge.
REQ-003 rst  input  1  Synchronous active-high reset.
REQ-004 start  input  1  Execute-stage DIV/DIVU issue request; sampled only in IDLE.
REQ-005 signed_div  input  1  1 selects DIV (signed), 0 selects DIVU (unsigned); sampled with start.
REQ-006 opa  input  32  Dividend (rs value after forwarding); sampled with start.
REQ-007 opb  input  32  Divisor (rt value after forwarding); sampled with start.
REQ-008 cancel  input  1  Abort from pipeline flush or exception; overrides start.
REQ-009 stall  output  1  Divide in progress; drives the hazard unit divstart input and freezes F/D/E.
REQ-010 ready  output  1  One-cycle pulse; result is valid for HI/LO write in the same cycle.
REQ-011 result  output  64  {HI = remainder[31:0], LO = quotient[31:0]}.

Function
REQ-012 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-013 IDLE with start=1, cancel=0 and opb!=0 SHALL latch the operand magnitudes, signed_div and the sign bits, clear a 6-bit iteration counter, and go to BUSY.
REQ-014 BUSY SHALL perform one restoring shift-subtract step per cycle on a 33-bit partial remainder, for exactly 32 cycles, then go to DONE.
REQ-015 DONE SHALL assert ready=1 for one cycle, load result, and return to IDLE.
REQ-016 Latency: start sampled at cycle 0 SHALL give ready=1 at cycle 33.
REQ-017 stall SHALL be combinational: 1 when (IDLE and start and !cancel) or BUSY, else 0; stall SHALL be 0 in DONE.
REQ-018 Unsigned mode SHALL treat opa and opb as 32-bit unsigned values.
REQ-019 Signed mode SHALL divide magnitudes, negate the quotient when the operand signs differ, and give the remainder the dividend's sign.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000, with no error indication.
REQ-021 Divide-by-zero (opb==0 at start) SHALL go IDLE->DONE directly, with stall=1 at cycle 0 only and ready=1 at cycle 1.
REQ-022 The divide-by-zero result SHALL be LO=0xFFFFFFFF and HI=opa in both signed and unsigned modes.
REQ-023 start SHALL be ignored in BUSY and DONE; operands are not re-sampled.
REQ-024 cancel=1 in any state SHALL force IDLE on the next edge, suppress ready and leave result unchanged.
REQ-025 cancel and start asserted together in IDLE SHALL leave the FSM in IDLE with stall=0.
REQ-026 result SHALL hold its last value until the next DONE.

Reset
REQ-027 While rst=1: state SHALL be IDLE, result 0, ready 0, counter 0, and stall 0 regardless of start.
REQ-028 Reset asserted mid-BUSY SHALL abandon the operation; no ready pulse SHALL follow.

Verification
REQ-029 Unsigned divide: start, divu, opa=100, opb=7 at cycle 0 -> stall=1 for cycles 0-32, ready=1 at cycle 33, result={HI=2, LO=14}.
REQ-030 Signed divide: opa=0xFFFFFFF9 (-7), opb=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF at cycle 33; the overflow case 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-031 Divide-by-zero: opa=0x1234, opb=0 -> stall=1 at cycle 0 only, ready=1 at cycle 1, LO=0xFFFFFFFF, HI=0x1234.
REQ-032 Cancel mid-operation: cancel=1 at cycle 10 -> IDLE at cycle 11, stall=0 from cycle 11, no ready pulse, result unchanged.
REQ-033 start held high through BUSY with changing opa/opb -> first operands used, single ready at cycle 33.
REQ-034 Reset mid-operation: rst=1 at cycle 5 -> stall=0, ready=0, result=0 at cycle 6; a new start at cycle 7 -> ready at cycle 40.
